// File: rtl/ad9280_cap.sv
// AD9280 capture engine: divides clk down to the ADC sample clock, optionally waits
// for a rising level crossing, fills a DEPTH-sample buffer and streams it out.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | buffer quiescent, waiting for arm
// WAIT_TRIG | comparing each new sample against trig_level for a rising crossing
// CAPTURE   | writing one buffer entry per new sample
// READOUT   | presenting entries 0..DEPTH-1 on the valid/ready port
module ad9280_cap #(
    parameter int CLK_DIV = 4,
    parameter int DEPTH   = 256
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_ad9280_clk,
    input  logic [7:0] i_ad9280_data,
    input  logic       i_arm,
    input  logic       i_trig_en,
    input  logic [7:0] i_trig_level,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    input  logic       i_rd_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TRIG = 2'd1,
        S_CAPTURE   = 2'd2,
        S_READOUT   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [DW-1:0]   r_div_cnt;
    logic            w_strobe;
    logic [7:0]      r_sample;
    logic            r_new;

    logic [7:0]      r_trig_level;
    logic            r_first;
    logic [7:0]      r_prev;
    logic [AW-1:0]   r_wr_addr;
    logic [AW-1:0]   r_rd_addr;
    logic            r_rd_valid;
    logic [7:0]      r_rd_data;
    logic [7:0]      r_mem [DEPTH];

    logic            w_trig;
    logic            w_we;
    logic            w_hs;
    logic            w_last_hs;
    logic            w_enter_ro;
    logic            w_rd_load;
    logic [AW-1:0]   w_raddr;

    // ------------------------------------------------------------------
    // ADC clock divider and sample register
    // ------------------------------------------------------------------
    assign w_strobe = (r_div_cnt == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_cnt <= '0;
        end else if (w_strobe) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Gated by reset so the pin sits low while the divider is held at zero.
    assign o_ad9280_clk = ~i_rst & (r_div_cnt < DIV_HALF);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sample <= '0;
            r_new    <= 1'b0;
        end else begin
            r_new <= w_strobe;
            if (w_strobe) begin
                r_sample <= i_ad9280_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_trig     = r_new & ~r_first & (r_prev < r_trig_level) & (r_sample >= r_trig_level);
    assign w_we       = r_new & ((r_state == S_CAPTURE) | ((r_state == S_WAIT_TRIG) & w_trig));
    assign w_hs       = r_rd_valid & i_rd_ready;
    assign w_last_hs  = (r_state == S_READOUT) & w_hs & (r_rd_addr == ADDR_LAST);
    assign w_enter_ro = (r_state == S_CAPTURE) & (w_next_state == S_READOUT);
    assign w_rd_load  = (r_state == S_READOUT) | w_enter_ro;

    // Look one entry ahead on a handshake so the output register never bubbles.
    assign w_raddr = (r_state != S_READOUT) ? '0 :
                     w_hs                   ? r_rd_addr + 1'b1 :
                                              r_rd_addr;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_arm) begin
                    w_next_state = i_trig_en ? S_WAIT_TRIG : S_CAPTURE;
                end
            end
            S_WAIT_TRIG: begin
                if (w_trig) begin
                    w_next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (r_new && (r_wr_addr == ADDR_LAST)) begin
                    w_next_state = S_READOUT;
                end
            end
            S_READOUT: begin
                if (w_last_hs) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        if (r_state != S_IDLE) begin
            o_busy = 1'b1;
        end
        if (w_last_hs) begin
            o_done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Capture / readout datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_trig_level <= '0;
            r_first      <= 1'b0;
            r_prev       <= '0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_arm) begin
                r_trig_level <= i_trig_level;
                r_wr_addr    <= '0;
                r_first      <= 1'b1;
            end
            if (w_we) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
            if ((r_state == S_WAIT_TRIG) && r_new) begin
                r_prev  <= r_sample;
                r_first <= 1'b0;
            end
            if (w_rd_load) begin
                r_rd_data <= r_mem[w_raddr];
            end
            if (r_state == S_READOUT) begin
                if (w_hs) begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                end
            end else begin
                r_rd_addr <= '0;
            end
            if (w_enter_ro) begin
                r_rd_valid <= 1'b1;
            end else if (w_last_hs) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    // Buffer contents survive reset; only written while capturing.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[r_wr_addr] <= r_sample;
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule
